// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Optional early-out for multiplies: MDU_EARLY_OUT_EN.
package mdu_pkg;

  localparam logic [1:0] KIND_MULT  = 2'b00;
  localparam logic [1:0] KIND_MULTU = 2'b01;
  localparam logic [1:0] KIND_DIV   = 2'b10;
  localparam logic [1:0] KIND_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

endpackage

// File: rtl/mdu_iter_core.sv
// One shift-add (multiply) or restoring-divide step per cycle.
// acc holds the high half / partial remainder, mq the low half / quotient.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mq
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] dif;
  logic             ge;

  always_comb begin
    sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    sh    = {acc_q, mq_q[WIDTH-1]};
    dif   = sh[WIDTH-1:0] - b_q;
    ge    = sh >= {1'b0, b_q};
    acc_d = acc_q;
    mq_d  = mq_q;
    b_d   = b_q;
    if (load) begin
      acc_d = '0;
      mq_d  = a_in;
      b_d   = b_in;
    end else if (step) begin
      if (is_div) begin
        // remainder < divisor, so the modular difference is exact
        acc_d = ge ? dif : sh[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], ge};
      end else begin
        acc_d = sum[WIDTH:1];
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      mq_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      b_q   <= b_d;
    end
  end

  assign acc = acc_q;
  assign mq  = mq_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO and the ID stall.
// MDU_EARLY_OUT_EN lets multiplies finish once the multiplier runs out.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             read_hilo,
  input  logic             write_hilo,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             done_q, done_d;
  logic             neg_q, neg_d, rneg_q, rneg_d;
  logic             div_q, div_d, dz_q, dz_d;

  logic             load, step;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] acc, mq;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quo, rem;
  logic             rest_zero;

  always_comb begin
    rs_neg = ~kind[0] & rs_val[WIDTH-1];
    rt_neg = ~kind[0] & rt_val[WIDTH-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (load ? kind[1] : div_q),
    .a_in   (kind[1] ? rs_mag : rt_mag),
    .b_in   (kind[1] ? rt_mag : rs_mag),
    .acc    (acc),
    .mq     (mq)
  );

  always_comb begin
    prod_raw  = {acc, mq};
    rest_zero = 1'b0;
`ifdef MDU_EARLY_OUT_EN
    // cnt_q steps done; realign the product for the skipped shifts
    prod_raw  = {acc, mq} >> (WIDTH - int'(cnt_q));
    rest_zero = ((mq >> 1) & ({WIDTH{1'b1}} >> (cnt_q + 1'b1))) == '0;
`endif
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo      = neg_q ? -mq : mq;
    rem      = rneg_q ? -acc : acc;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    dz_d    = dz_q;
    dvd_d   = dvd_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!flush) begin
            load    = 1'b1;
            cnt_d   = '0;
            neg_d   = rs_neg ^ rt_neg;
            rneg_d  = rs_neg;
            div_d   = kind[1];
            dz_d    = kind[1] & (rt_val == '0);
            dvd_d   = rs_val;
            state_d = RUN;
`ifdef MDU_EARLY_OUT_EN
            if (!kind[1] && rt_mag == '0) state_d = FIX;
`endif
          end
        end else if (write_hilo) begin
          if (wr_sel) hi_d = wr_data;
          else lo_d = wr_data;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
          if (!div_q && rest_zero) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      dvd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      dvd_q   <= dvd_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign stall_out = busy & (read_hilo | start | write_hilo);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit (HI/LO) for the 5-stage MIPS pipeline.
- Sequences a shared shift-add/restoring-divide core over multiple cycles and owns the HI/LO registers.
- Raises a stall for the ID stage while an operation is in flight, in the same way the load-use interlock holds IF/ID.
- Sits beside the EX-stage ALU; start comes from ID/EX, HI/LO reads come from the MFHI/MFLO path.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  MULT/MULTU/DIV/DIVU present in EX and not stalled.
- kind  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  multiplicand / dividend (forwarded value).
- rt_val  in  WIDTH  multiplier / divisor (forwarded value).
- read_hilo  in  1  MFHI/MFLO in ID.
- write_hilo  in  1  MTHI/MTLO in EX.
- wr_sel  in  1  0 = LO, 1 = HI.
- wr_data  in  WIDTH  MTHI/MTLO data.
- flush  in  1  squash the in-flight operation (branch/exception).
- stall_out  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any state): FSM to IDLE; counter = 0; hi = lo = 0; done = 0; busy = 0. Internal accumulators are cleared.
- States and transitions:
  - IDLE: on start, latch operand magnitudes, signs and kind; counter = 0; go to RUN.
  - RUN: one core iteration per cycle; counter++. When counter == WIDTH-1, go to FIX.
  - FIX: apply sign correction; write hi/lo; done = 1 the following cycle; go to IDLE.
- Latency: start sampled at edge E0 → hi/lo valid after edge E0+WIDTH+1 (33 cycles for WIDTH = 32). done is high for exactly one cycle, aligned with the new hi/lo.
- Arithmetic:
  - MULT/MULTU: 2·WIDTH product; hi = upper half, lo = lower half.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed ops use magnitudes internally. Product is negated if signs differ. Quotient is negated if signs differ; the remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): lo = all ones, hi = dividend; full latency still applies.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- stall_out (combinational) = busy & (read_hilo | start | write_hilo). A new MDU op or an MTHI/MTLO while busy is held, never dropped. start is ignored while busy.
- write_hilo in IDLE: the selected register is written at the next edge.
- start and write_hilo together in IDLE is illegal; start wins and the write is ignored (the bench flags it with an assertion).
- flush in RUN/FIX: return to IDLE at the next edge; hi/lo unchanged; no done. flush in IDLE has no effect.
- flush and start in the same IDLE cycle: flush wins; the op is not started.
- read_hilo in the same cycle as done: no stall; the new values are visible.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: multiplies exit RUN to FIX as soon as the remaining multiplier magnitude bits are all zero. Minimum latency is 2 cycles (start edge plus FIX); divides keep the fixed latency. done/stall_out semantics are unchanged.
- Undefined: fixed WIDTH+1 latency for every operation.

Decomposition:
- Package mdu_pkg:
  - kind encodings (KIND_MULT, KIND_MULTU, KIND_DIV, KIND_DIVU);
  - state enum (IDLE, RUN, FIX);
  - MIPS funct constants (MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13).
- Sub-module mdu_iter_core: the per-iteration datapath (add/shift for multiply, subtract/restore for divide), driven by the sequencer's step/op signals.
- The FSM, counter, sign fixup, HI/LO and stall logic remain in mdu_sequencer.

Test Plan (MDU_EARLY_OUT_EN undefined unless stated):
1. MULTU 0xFFFFFFFF × 0x00000002 → done after 33 cycles; hi = 0x00000001, lo = 0xFFFFFFFE.
2. MULT 0xFFFFFFFD (−3) × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
3. DIVU 10 / 0 → lo = 0xFFFFFFFF, hi = 0x0000000A. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
4. read_hilo held from cycle 5 after start → stall_out = 1 through the FIX cycle, 0 in the done cycle. A second start raised mid-op is stalled and then executes, giving a correct second result.
5. flush at cycle 10 of a DIV, with prior hi = 0x11, lo = 0x22 → busy = 0 next cycle; hi/lo still 0x11/0x22; no done pulse.
6. reset asserted asynchronously mid-RUN → busy, hi, lo = 0 immediately. With MDU_EARLY_OUT_EN: MULTU 7 × 1 → done within 3 cycles; hi = 0, lo = 7.
